// File: rtl/key_conditioner_if.sv
// Pushbutton/switch bundle between the board pins and the key conditioner.
interface key_conditioner_if;
    logic [3:0] KEY_n;
    logic [3:0] SW_raw;
    logic [3:0] KEY;
    logic [3:0] key_level;
    logic [3:0] SW;

    modport master (output KEY_n, output SW_raw, input KEY, input key_level, input SW);
    modport slave  (input KEY_n, input SW_raw, output KEY, output key_level, output SW);
endinterface

// File: rtl/key_conditioner.sv
// Synchronises, debounces and pulse-encodes four pushbuttons; captures switches on save.
// Optional auto-repeat for held keys is enabled with `define KEY_AUTOREPEAT_EN.
module key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000,
    parameter logic [3:0]  REPEAT_MASK     = 4'b0001
) (
    input  logic             CLOCK50,
    input  logic             reset_n,
    key_conditioner_if.slave bus
);
    localparam int unsigned N_KEYS  = 4;
    localparam int unsigned CNT_W   = 24;
    localparam int unsigned CNT_MAX = 32'h00FF_FFFF;

    if (DEBOUNCE_CYCLES == 0 || DEBOUNCE_CYCLES > CNT_MAX) begin : g_bad_cfg
        $error("key_conditioner: DEBOUNCE_CYCLES must be within 1..2^24-1");
    end

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        HELD         = 2'd2,
        RELEASE_PEND = 2'd3
    } key_state_e;

    logic [N_KEYS-1:0] key_meta, key_sync;
    logic [N_KEYS-1:0] sw_meta, sw_sync;

    key_state_e        state_q [N_KEYS];
    key_state_e        state_d [N_KEYS];
    logic [CNT_W-1:0]  cnt_q   [N_KEYS];
    logic [CNT_W-1:0]  cnt_d   [N_KEYS];

    logic [N_KEYS-1:0] press_c;
    logic [N_KEYS-1:0] key_c;
    logic [N_KEYS-1:0] level_c;

`ifdef KEY_AUTOREPEAT_EN
    // Repeat intervals may exceed 24 bits (25M default), so these counters widen to fit.
    localparam int unsigned RPT_LONG = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_NEED = $clog2(RPT_LONG + 1);
    localparam int unsigned RPT_W    = (RPT_NEED > CNT_W) ? RPT_NEED : CNT_W;

    logic [RPT_W-1:0]  rpt_cnt_q [N_KEYS];
    logic [RPT_W-1:0]  rpt_cnt_d [N_KEYS];
    logic [N_KEYS-1:0] rpt_first_q, rpt_first_d;
    logic [N_KEYS-1:0] rpt_c;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    // Per-key debounce FSM next state, plus pulse arbitration.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_c = '0;
        level_c = '0;
        key_c   = '0;
`ifdef KEY_AUTOREPEAT_EN
        rpt_cnt_d   = rpt_cnt_q;
        rpt_first_d = rpt_first_q;
        rpt_c       = '0;
`endif
        for (int i = 0; i < N_KEYS; i++) begin
            case (state_q[i])
                RELEASED: begin
                    if (!key_sync[i]) begin
                        state_d[i] = PRESS_PEND;
                        cnt_d[i]   = CNT_W'(1);
                    end
                end
                PRESS_PEND: begin
                    if (key_sync[i]) begin
                        state_d[i] = RELEASED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES)) begin
                        state_d[i] = HELD;
                        cnt_d[i]   = '0;
                        press_c[i] = 1'b1;
                    end else begin
                        cnt_d[i] = sat_inc(cnt_q[i]);
                    end
                end
                HELD: begin
                    if (key_sync[i]) begin
                        state_d[i] = RELEASE_PEND;
                        cnt_d[i]   = CNT_W'(1);
                    end
                end
                RELEASE_PEND: begin
                    if (!key_sync[i]) begin
                        state_d[i] = HELD;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES)) begin
                        state_d[i] = RELEASED;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = sat_inc(cnt_q[i]);
                    end
                end
                default: begin
                    state_d[i] = RELEASED;
                    cnt_d[i]   = '0;
                end
            endcase
            level_c[i] = (state_d[i] == HELD) || (state_d[i] == RELEASE_PEND);
`ifdef KEY_AUTOREPEAT_EN
            // Count cycles since the last pulse while HELD; any exit restarts the delay.
            if (state_d[i] == HELD) begin
                if (state_q[i] != HELD) begin
                    rpt_cnt_d[i]   = RPT_W'(1);
                    rpt_first_d[i] = 1'b1;
                end else if (rpt_cnt_q[i] == (rpt_first_q[i] ? RPT_W'(REPEAT_DELAY)
                                                             : RPT_W'(REPEAT_PERIOD))) begin
                    rpt_c[i]       = REPEAT_MASK[i];
                    rpt_cnt_d[i]   = RPT_W'(1);
                    rpt_first_d[i] = 1'b0;
                end else if (rpt_cnt_q[i] != '1) begin
                    rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_W'(1);
                end
            end else begin
                rpt_cnt_d[i]   = '0;
                rpt_first_d[i] = 1'b1;
            end
`endif
        end
`ifdef KEY_AUTOREPEAT_EN
        key_c = press_c | rpt_c;
`else
        key_c = press_c;
`endif
        // A reset pulse wins: it blanks every other pulse in its cycle.
        if (key_c[1]) begin
            key_c = 4'b0010;
        end
    end

    always_ff @(posedge CLOCK50 or negedge reset_n) begin
        if (!reset_n) begin
            key_meta <= '1;
            key_sync <= '1;
            sw_meta  <= '0;
            sw_sync  <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                state_q[i] <= RELEASED;
                cnt_q[i]   <= '0;
            end
            bus.KEY       <= '0;
            bus.key_level <= '0;
            bus.SW        <= '0;
        end else begin
            key_meta <= bus.KEY_n;
            key_sync <= key_meta;
            sw_meta  <= bus.SW_raw;
            sw_sync  <= sw_meta;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bus.KEY       <= key_c;
            bus.key_level <= level_c;
            if (key_c[3]) begin
                bus.SW <= sw_sync;
            end
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    always_ff @(posedge CLOCK50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_KEYS; i++) begin
                rpt_cnt_q[i] <= '0;
            end
            rpt_first_q <= '1;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
        end
    end
`endif

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: vector table plus scoreboarded press pulses.
module tb_key_conditioner;
    logic clk;
    logic reset_n;
    int   cyc;
    int   checks;
    int   errors;

    key_conditioner_if bus ();

    key_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8),
        .REPEAT_MASK    (4'b0001)
    ) dut (
        .CLOCK50(clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct {
        int         cyc;
        logic [3:0] key;
        logic [3:0] sw;
    } exp_t;

    typedef struct {
        logic [3:0] press;
        logic [3:0] sw_raw;
        logic [3:0] exp_key;
        logic [3:0] exp_sw;
    } vec_t;

    exp_t       sbq[$];
    vec_t       vecs[8];
    logic [3:0] sw_model;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, req, cyc);
        end
    endtask

    task automatic expect_pulse(input int c, input logic [3:0] k, input logic [3:0] s);
        exp_t e;
        e.cyc = c;
        e.key = k;
        e.sw  = s;
        sbq.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Every nonzero KEY must match the next scheduled pulse.
    always @(negedge clk) begin
        exp_t e;
        if (bus.KEY !== 4'b0000) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse actual=KEY %b SW %b required=no pulse cyc=%0d",
                         bus.KEY, bus.SW, cyc);
            end else begin
                e = sbq.pop_front();
                check("pulse_cyc", 32'(cyc), 32'(e.cyc));
                check("pulse_key", 32'(bus.KEY), 32'(e.key));
                check("pulse_sw", 32'(bus.SW), 32'(e.sw));
            end
        end
    end

    initial begin
        int n;
        int m;
        int offs[5];
        exp_t e;
        offs = '{20, 28, 36, 44, 52};
        cyc = 0;
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        bus.KEY_n = 4'hF;
        bus.SW_raw = 4'h0;
        sw_model = 4'h0;

        vecs[0] = '{4'b1000, 4'b1010, 4'b1000, 4'b1010};
        vecs[1] = '{4'b0100, 4'b0101, 4'b0100, 4'b1010};
        vecs[2] = '{4'b1010, 4'b0110, 4'b0010, 4'b1010};
        vecs[3] = '{4'b0001, 4'b0000, 4'b0001, 4'b1010};
        vecs[4] = '{4'b1101, 4'b0011, 4'b1101, 4'b0011};
        vecs[5] = '{4'b1111, 4'b1100, 4'b0010, 4'b0011};
        vecs[6] = '{4'b0011, 4'b1111, 4'b0010, 4'b0011};
        vecs[7] = '{4'b1000, 4'b0111, 4'b1000, 4'b0111};

        repeat (3) @(negedge clk);
        check("reset_key", 32'(bus.KEY), 32'h0);
        check("reset_level", 32'(bus.key_level), 32'h0);
        check("reset_sw", 32'(bus.SW), 32'h0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Table: press, hold 10 cycles, release, settle.
        for (int i = 0; i < 8; i++) begin
            n = cyc;
            bus.KEY_n  = ~vecs[i].press;
            bus.SW_raw = vecs[i].sw_raw;
            expect_pulse(n + 7, vecs[i].exp_key, vecs[i].exp_sw);
            wait_until(n + 9);
            check("held_level", 32'(bus.key_level), 32'(vecs[i].press));
            wait_until(n + 10);
            bus.KEY_n = 4'hF;
            wait_until(n + 22);
            check("released_level", 32'(bus.key_level), 32'h0);
            check("sw_hold", 32'(bus.SW), 32'(vecs[i].exp_sw));
            sw_model = vecs[i].exp_sw;
        end

        // Bounce on execute: low 3, high 1, then steady low.
        n = cyc;
        bus.KEY_n = 4'b1011;
        wait_until(n + 3);
        bus.KEY_n = 4'b1111;
        wait_until(n + 4);
        bus.KEY_n = 4'b1011;
        expect_pulse(n + 4 + 7, 4'b0100, sw_model);
        wait_until(n + 14);
        bus.KEY_n = 4'hF;
        wait_until(n + 26);

        // Long delete hold, then release: level falls late, no release pulse.
        n = cyc;
        bus.KEY_n = 4'b1110;
        expect_pulse(n + 7, 4'b0001, sw_model);
`ifdef KEY_AUTOREPEAT_EN
        for (int k = 0; k < 5; k++) expect_pulse(n + 7 + offs[k], 4'b0001, sw_model);
`endif
        wait_until(n + 60);
        m = cyc;
        bus.KEY_n = 4'hF;
        wait_until(m + 6);
        check("release_level_high", 32'(bus.key_level), 32'h1);
        wait_until(m + 7);
        check("release_level_low", 32'(bus.key_level), 32'h0);
        wait_until(m + 20);

        // Reset while execute is at count 2 and delete is held.
        n = cyc;
        bus.KEY_n = 4'b1110;
        expect_pulse(n + 7, 4'b0001, sw_model);
        wait_until(n + 10);
        bus.KEY_n = 4'b1010;
        wait_until(n + 14);
        check("pre_reset_level", 32'(bus.key_level), 32'h1);
        reset_n = 1'b0;
        #1;
        check("midreset_key", 32'(bus.KEY), 32'h0);
        check("midreset_level", 32'(bus.key_level), 32'h0);
        check("midreset_sw", 32'(bus.SW), 32'h0);
        sw_model = 4'h0;
        repeat (3) @(negedge clk);
        m = cyc;
        reset_n = 1'b1;
        expect_pulse(m + 7, 4'b0101, 4'b0000);
        wait_until(m + 10);
        bus.KEY_n = 4'hF;
        wait_until(m + 30);

        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_pulse actual=none required=KEY %b at cyc %0d", e.key, e.cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive stable cycles needed to accept a key level change (20 ms at 50 MHz); legal range 1 to 2^24-1.
REQ-002 SHALL have parameter REPEAT_DELAY, default 25000000, meaning the cycle count from a press pulse to the first auto-repeat pulse.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 10000000, meaning the cycle count between subsequent auto-repeat pulses.
REQ-004 SHALL have parameter REPEAT_MASK, default 4'b0001, meaning the set of keys eligible for auto-repeat (bit 0, delete).
REQ-005 SHALL have port CLOCK50  input  1  system clock; the block uses one clock, rising edge only.
REQ-006 SHALL have port reset_n  input  1  reset; asynchronous assert, active-low.
REQ-007 SHALL have port KEY_n  input  4  raw board pushbuttons, active-low, asynchronous: [3] save, [2] execute, [1] reset, [0] delete.
REQ-008 SHALL have port SW_raw  input  4  raw slide switches, asynchronous: [1:0] direction, [3:2] torque.
REQ-009 SHALL have port KEY  output  4  active-high one-cycle press pulses feeding FSM KEY[3:0].
REQ-010 SHALL have port key_level  output  4  debounced active-high held level per key.
REQ-011 SHALL have port SW  output  4  switch value captured at the last accepted save pulse, feeding FSM SW[3:0].

Function
REQ-012 SHALL pass each KEY_n bit and each SW_raw bit through an independent 2-flop synchronizer before any other use.
REQ-013 SHALL run an independent per-key FSM with states RELEASED, PRESS_PEND, HELD and RELEASE_PEND.
REQ-014 SHALL move from RELEASED to PRESS_PEND on a synced low, and return from PRESS_PEND to RELEASED with the counter cleared on any synced high (glitch).
REQ-015 SHALL move from PRESS_PEND to HELD when the counter reaches DEBOUNCE_CYCLES, asserting KEY[i] for exactly that one cycle.
REQ-016 SHALL handle release symmetrically: HELD goes to RELEASE_PEND on a synced high, RELEASE_PEND returns to HELD on a synced low, and RELEASE_PEND goes to RELEASED after DEBOUNCE_CYCLES; release produces no pulse.
REQ-017 SHALL assert the first KEY[i] pulse exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples a new stable low.
REQ-018 SHALL drive key_level[i] high in HELD and RELEASE_PEND, and low otherwise.
REQ-019 SHALL update SW from the synchronized switches on the same edge that KEY[3] asserts, so SW is valid in the pulse cycle; SW SHALL hold otherwise.
REQ-020 SHALL resolve simultaneous pulses as follows: when KEY[1] (reset) pulses, KEY[3], KEY[2] and KEY[0] are forced low that cycle, and SW is not updated.
REQ-021 SHALL allow any other pulse combination to assert in the same cycle.
REQ-022 SHALL size each counter at 24 bits and saturate it; no wrap-around is permitted.

Reset
REQ-023 SHALL, while reset_n is low, immediately force all FSMs to RELEASED, clear all counters and synchronizers to the released/zero level, and drive KEY=0, key_level=0 and SW=0.
REQ-024 SHALL treat a key held across reset deassertion as a new press, pulsing after DEBOUNCE_CYCLES+2 edges.
REQ-025 SHALL abort any count in progress when reset asserts mid-debounce; no pulse SHALL escape.

Configuration
REQ-026 SHALL, with KEY_AUTOREPEAT_EN defined, pulse KEY[i] for keys in REPEAT_MASK while in HELD: once at REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles, until HELD is left.
REQ-027 SHALL apply the REQ-020 suppression rule to repeat pulses as well.
REQ-028 SHALL, with KEY_AUTOREPEAT_EN undefined, omit the repeat counters and logic entirely, emit exactly one pulse per press, and ignore REPEAT_DELAY, REPEAT_PERIOD and REPEAT_MASK.

Verification
Benches SHALL use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20 and REPEAT_PERIOD=8.
REQ-029 SHALL cover a clean press: KEY_n[3] goes low with SW_raw=4'b1010 -> KEY=4'b1000 for one cycle exactly 6 edges later, SW=4'b1010 in that same cycle.
REQ-030 SHALL cover a bounce: KEY_n[2] low for 3 cycles, high for 1 cycle, then low steady -> no pulse during the bounce, one pulse 6 edges after the final low.
REQ-031 SHALL cover a simultaneous press: KEY_n[3] and KEY_n[1] go low on the same edge -> KEY=4'b0010 only, and SW is unchanged.
REQ-032 SHALL cover release: hold KEY_n[0] for 50 cycles, then release -> key_level[0] falls 6 edges after release, and no release pulse occurs.
REQ-033 SHALL cover reset mid-count: reset_n pulsed low at count 2 -> all outputs 0 at once, and a fresh pulse 6 edges after reset_n rises if the key is still held.
REQ-034 SHALL cover auto-repeat: with KEY_AUTOREPEAT_EN, hold KEY_n[0] for 60 cycles -> pulses at press+0, +20, +28, +36, +44, +52; without the macro, a single pulse.
